// File: rtl/ahbl_sram_ecc_pkg.sv
// Shared types and Hsiao (39,32) SECDED constants for the SRAM ECC storage stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, codeword field positions, H-matrix columns, check-bit helper.
// Optional feature macro consumed by users of this package: AHBL_SRAM_ECC_EN.
package ahbl_sram_ecc_pkg;

  localparam int DATA_W  = 32;
  localparam int CHK_W   = 7;
  localparam int CW_W    = 40;
  localparam int CHK_LSB = 32;
  localparam int CHK_MSB = 38;
  localparam int PAD_BIT = 39;
  localparam int NBYTES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_RD = 2'd1,
    ST_RMW_WR = 2'd2
  } state_t;

  // Data columns: the first 32 weight-3 7-bit vectors in ascending order.
  // Listed from data bit 31 down to data bit 0.
  localparam logic [DATA_W-1:0][CHK_W-1:0] H_DATA_COLS = {
    7'h62, 7'h61, 7'h58, 7'h54, 7'h52, 7'h51, 7'h4C, 7'h4A,
    7'h49, 7'h46, 7'h45, 7'h43, 7'h38, 7'h34, 7'h32, 7'h31,
    7'h2C, 7'h2A, 7'h29, 7'h26, 7'h25, 7'h23, 7'h1C, 7'h1A,
    7'h19, 7'h16, 7'h15, 7'h13, 7'h0E, 7'h0D, 7'h0B, 7'h07
  };

  // Check-bit columns are unit vectors, listed from check bit 6 down to 0.
  localparam logic [CHK_W-1:0][CHK_W-1:0] H_CHK_COLS = {
    7'h40, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01
  };

  function automatic logic [CHK_W-1:0] hsiao_chk(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c = c ^ (H_DATA_COLS[i] & {CHK_W{d[i]}});
    end
    return c;
  endfunction

endpackage

// File: rtl/ahbl_sram_ecc_codec.sv
// Hsiao (39,32) SECDED encoder plus syndrome decoder/corrector.
// Latency: purely combinational.
// Backpressure: none; no state.
// Ports: enc_data -> enc_cw (bit 39 zero); dec_cw -> dec_data corrected, dec_sb / dec_db flags.
module ahbl_sram_ecc_codec
  import ahbl_sram_ecc_pkg::*;
(
  input  logic [DATA_W-1:0] enc_data,
  output logic [CW_W-1:0]   enc_cw,
  input  logic [CW_W-1:0]   dec_cw,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_sb,
  output logic              dec_db
);

  logic [CHK_W-1:0] syn;
  logic             hit;
  logic             unused_pad;

  assign unused_pad = dec_cw[PAD_BIT];
  assign enc_cw     = {1'b0, hsiao_chk(enc_data), enc_data};

  // A syndrome equal to one H column is a single flipped bit at that column;
  // any other non-zero syndrome is treated as uncorrectable.
  always_comb begin
    syn      = hsiao_chk(dec_cw[DATA_W-1:0]) ^ dec_cw[CHK_MSB:CHK_LSB];
    dec_data = dec_cw[DATA_W-1:0];
    hit      = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (syn == H_DATA_COLS[i]) begin
        dec_data[i] = ~dec_data[i];
        hit         = 1'b1;
      end
    end
    for (int j = 0; j < CHK_W; j++) begin
      if (syn == H_CHK_COLS[j]) hit = 1'b1;
    end
    dec_sb = hit;
    dec_db = (syn != '0) && !hit;
  end

endmodule

// File: rtl/ahbl_sram_ecc_mem.sv
// SRAM storage stage behind the AHB-Lite SRAM interface; SECDED-protected, partial writes via RMW.
// Latency: read data one cycle after ren; full writes single cycle; partial writes stall 2 cycles.
// Backpressure: mem_busy high during RMW; requests presented then are ignored and must be held.
// Ports: HCLK/HRESETN; mem_ren/wen/addr/byteen/wdata request; mem_rdata/mem_busy response;
//        ecc_sb_err/ecc_db_err pulses, ecc_sb_count with ecc_clr_count, ecc_inj_sb/db fault injection.
// Build option: AHBL_SRAM_ECC_EN enables SECDED; without it a plain byte-enable RAM is built.
module ahbl_sram_ecc_mem
  import ahbl_sram_ecc_pkg::*;
#(
  parameter int MEM_DEPTH  = 512,
  parameter int MEM_AWIDTH = 9
)(
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [MEM_AWIDTH-1:0] mem_addr,
  input  logic [3:0]            mem_byteen,
  input  logic [39:0]           mem_wdata,
  output logic [39:0]           mem_rdata,
  output logic                  mem_busy,
  output logic                  ecc_sb_err,
  output logic                  ecc_db_err,
  output logic [15:0]           ecc_sb_count,
  input  logic                  ecc_clr_count,
  input  logic                  ecc_inj_sb,
  input  logic                  ecc_inj_db
);

`ifdef AHBL_SRAM_ECC_EN

  state_t                state, state_nxt;
  logic [CW_W-1:0]       ram [MEM_DEPTH];
  logic [CW_W-1:0]       ram_q;
  logic                  rd_vld;
  logic [MEM_AWIDTH-1:0] rmw_addr;
  logic [NBYTES-1:0]     rmw_be;
  logic [DATA_W-1:0]     rmw_data;
  logic                  rmw_inj_sb, rmw_inj_db;

  logic                  idle, wr_full, wr_part, rd_acc, ram_rd_en, ram_wr_en;
  logic [MEM_AWIDTH-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data, dec_data, merged;
  logic [CW_W-1:0]       enc_cw, wr_cw;
  logic                  inj_sb, inj_db, dec_sb, dec_db;

  logic [DATA_W-1:0]     unused_enc_data;
  logic                  unused_enc_sb, unused_enc_db;
  logic [CW_W-1:0]       unused_dec_cw;
  logic [7:0]            unused_wpad;

  assign unused_wpad = mem_wdata[39:32];

  assign idle      = (state == ST_IDLE);
  assign wr_full   = idle && mem_wen && (mem_byteen == 4'hF);
  assign wr_part   = idle && mem_wen && (mem_byteen != 4'h0) && (mem_byteen != 4'hF);
  assign rd_acc    = idle && mem_ren && !mem_wen;
  // The RMW old-word read shares the user read path and output register.
  assign ram_rd_en = rd_acc || wr_part;

  always_comb begin
    state_nxt = state;
    ram_wr_en = 1'b0;
    case (state)
      ST_IDLE: begin
        ram_wr_en = wr_full;
        if (wr_part) state_nxt = ST_RMW_RD;
      end
      ST_RMW_RD: state_nxt = ST_RMW_WR;
      ST_RMW_WR: begin
        // An uncorrectable old word is left untouched rather than re-encoded.
        ram_wr_en = !dec_db;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    merged = dec_data;
    for (int i = 0; i < NBYTES; i++) begin
      if (rmw_be[i]) merged[8*i +: 8] = rmw_data[8*i +: 8];
    end
  end

  assign wr_addr = idle ? mem_addr : rmw_addr;
  assign wr_data = idle ? mem_wdata[DATA_W-1:0] : merged;
  assign inj_sb  = idle ? ecc_inj_sb : rmw_inj_sb;
  assign inj_db  = idle ? ecc_inj_db : rmw_inj_db;
  // Double injection flips bits 0 and 1; it dominates a simultaneous single injection.
  assign wr_cw   = enc_cw ^ {{(CW_W-2){1'b0}}, inj_db, inj_sb | inj_db};

  ahbl_sram_ecc_codec u_enc (
    .enc_data (wr_data),
    .enc_cw   (enc_cw),
    .dec_cw   ('0),
    .dec_data (unused_enc_data),
    .dec_sb   (unused_enc_sb),
    .dec_db   (unused_enc_db)
  );

  ahbl_sram_ecc_codec u_dec (
    .enc_data ('0),
    .enc_cw   (unused_dec_cw),
    .dec_cw   (ram_q),
    .dec_data (dec_data),
    .dec_sb   (dec_sb),
    .dec_db   (dec_db)
  );

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state        <= ST_IDLE;
      ram_q        <= '0;
      rd_vld       <= 1'b0;
      rmw_addr     <= '0;
      rmw_be       <= '0;
      rmw_data     <= '0;
      rmw_inj_sb   <= 1'b0;
      rmw_inj_db   <= 1'b0;
      ecc_sb_count <= '0;
    end else begin
      state  <= state_nxt;
      rd_vld <= ram_rd_en;
      if (ram_rd_en) ram_q <= ram[mem_addr];
      if (wr_part) begin
        rmw_addr   <= mem_addr;
        rmw_be     <= mem_byteen;
        rmw_data   <= mem_wdata[DATA_W-1:0];
        rmw_inj_sb <= ecc_inj_sb;
        rmw_inj_db <= ecc_inj_db;
      end
      if (ecc_clr_count) ecc_sb_count <= '0;
      else if (ecc_sb_err && (ecc_sb_count != 16'hFFFF)) ecc_sb_count <= ecc_sb_count + 16'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (ram_wr_en) ram[wr_addr] <= wr_cw;
  end

  // Flags live in the read word until the next read; the pulses only in the cycle after a read.
  assign mem_rdata  = {6'b0, dec_db, dec_sb, dec_data};
  assign mem_busy   = !idle;
  assign ecc_sb_err = rd_vld && dec_sb;
  assign ecc_db_err = rd_vld && dec_db;

`else

  logic [DATA_W-1:0] ram [MEM_DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [10:0]       unused_in;

  assign unused_in = {mem_wdata[39:32], ecc_clr_count, ecc_inj_sb, ecc_inj_db};

  always_ff @(posedge HCLK) begin
    if (mem_wen) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (mem_byteen[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) ram_q <= '0;
    else if (mem_ren && !mem_wen) ram_q <= ram[mem_addr];
  end

  assign mem_rdata    = {8'h00, ram_q};
  assign mem_busy     = 1'b0;
  assign ecc_sb_err   = 1'b0;
  assign ecc_db_err   = 1'b0;
  assign ecc_sb_count = '0;

`endif

endmodule

// File: tb/tb_ahbl_sram_ecc_mem.sv
// Self-checking bench for ahbl_sram_ecc_mem against a word/fault-state reference model.
// Latency: reads checked one cycle after ren; RMW stall checked cycle by cycle.
// Backpressure: requests during mem_busy are driven and must be ignored.
`timescale 1ns/1ps
module tb_ahbl_sram_ecc_mem;

`ifdef AHBL_SRAM_ECC_EN
  localparam bit ECC = 1'b1;
`else
  localparam bit ECC = 1'b0;
`endif

  logic        HCLK;
  logic        HRESETN;
  logic        mem_ren, mem_wen;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_byteen;
  logic [39:0] mem_wdata;
  logic [39:0] mem_rdata;
  logic        mem_busy, ecc_sb_err, ecc_db_err;
  logic [15:0] ecc_sb_count;
  logic        ecc_clr_count, ecc_inj_sb, ecc_inj_db;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  ahbl_sram_ecc_mem dut (
    .HCLK          (HCLK),
    .HRESETN       (HRESETN),
    .mem_ren       (mem_ren),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_byteen    (mem_byteen),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_busy      (mem_busy),
    .ecc_sb_err    (ecc_sb_err),
    .ecc_db_err    (ecc_db_err),
    .ecc_sb_count  (ecc_sb_count),
    .ecc_clr_count (ecc_clr_count),
    .ecc_inj_sb    (ecc_inj_sb),
    .ecc_inj_db    (ecc_inj_db)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: true data per word plus its fault state (0 clean, 1 one bit flipped, 2 two bits).
  logic [31:0] m_data [16];
  int          m_flt  [16];
  int unsigned m_cnt;
  logic [39:0] m_last;
  bit          m_last_ok;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic int inj_state(input bit isb, input bit idb);
    if (!ECC) return 0;
    return idb ? 2 : (isb ? 1 : 0);
  endfunction

  function automatic logic [39:0] rd_word(input logic [3:0] a);
    return {7'b0, (m_flt[a] == 1), m_data[a]};
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_in();
    mem_ren = 1'b0; mem_wen = 1'b0; ecc_clr_count = 1'b0;
    ecc_inj_sb = 1'b0; ecc_inj_db = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    mem_addr = {5'd0, a}; mem_ren = 1'b1;
    tick();
    mem_ren = 1'b0;
    if (m_flt[a] != 2) begin
      chk("rd_word", mem_rdata, rd_word(a));
      m_last = rd_word(a); m_last_ok = 1'b1;
    end else begin
      chk("rd_db_flags", mem_rdata[39:32], 8'h02);
      m_last_ok = 1'b0;
    end
    chk("rd_sb_pulse", ecc_sb_err, m_flt[a] == 1);
    chk("rd_db_pulse", ecc_db_err, m_flt[a] == 2);
    chk("rd_busy", mem_busy, 1'b0);
    if (m_flt[a] == 1 && m_cnt != 32'hFFFF) m_cnt++;
    tick();
    chk("rd_pulse_end", {ecc_sb_err, ecc_db_err}, 2'b00);
    chk("rd_sb_count", ecc_sb_count, m_cnt);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d,
                          input bit isb, input bit idb, input bit with_ren, input bit stray);
    bit part;
    int old;
    part = ECC && (be != 4'h0) && (be != 4'hF);
    old  = m_flt[a];
    mem_addr = {5'd0, a}; mem_byteen = be; mem_wdata = {8'($urandom), d};
    mem_wen = 1'b1; mem_ren = with_ren; ecc_inj_sb = isb; ecc_inj_db = idb;
    tick();
    idle_in();
    if (!part) begin
      chk("wr_busy", mem_busy, 1'b0);
      chk("wr_pulses", {ecc_sb_err, ecc_db_err}, 2'b00);
      if (m_last_ok) chk("wr_rdata_hold", mem_rdata, m_last);
      if (be != 4'h0) begin
        m_data[a] = merge(m_data[a], be, d);
        m_flt[a]  = inj_state(isb, idb);
      end
    end else begin
      chk("rmw_busy_rd", mem_busy, 1'b1);
      chk("rmw_sb_pulse", ecc_sb_err, old == 1);
      chk("rmw_db_pulse", ecc_db_err, old == 2);
      if (old == 1 && m_cnt != 32'hFFFF) m_cnt++;
      if (old != 2) begin
        m_last = {7'b0, (old == 1), m_data[a]}; m_last_ok = 1'b1;
        chk("rmw_old_word", mem_rdata, m_last);
      end else begin
        m_last_ok = 1'b0;
      end
      if (stray) begin
        mem_addr = 9'($urandom_range(0, 15)); mem_byteen = 4'($urandom);
        mem_wdata = {8'h00, 32'($urandom)}; mem_wen = 1'($urandom_range(0, 1)); mem_ren = 1'b1;
      end
      tick();
      chk("rmw_busy_wr", mem_busy, 1'b1);
      chk("rmw_pulse_end", {ecc_sb_err, ecc_db_err}, 2'b00);
      chk("rmw_sb_count", ecc_sb_count, m_cnt);
      tick();
      idle_in();
      chk("rmw_done", mem_busy, 1'b0);
      if (m_last_ok) chk("rmw_rdata_hold", mem_rdata, m_last);
      if (old != 2) begin
        m_data[a] = merge(m_data[a], be, d);
        m_flt[a]  = inj_state(isb, idb);
      end
    end
  endtask

  task automatic do_clr();
    ecc_clr_count = 1'b1;
    tick();
    ecc_clr_count = 1'b0;
    m_cnt = 0;
    chk("clr_count", ecc_sb_count, m_cnt);
  endtask

  initial begin
    HRESETN = 1'b0; idle_in(); mem_addr = '0; mem_byteen = '0; mem_wdata = '0;
    m_cnt = 0; m_last = '0; m_last_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin m_data[i] = '0; m_flt[i] = 0; end
    repeat (3) tick();
    chk("reset_rdata", mem_rdata, 40'h0);
    chk("reset_busy", mem_busy, 1'b0);
    chk("reset_pulses", {ecc_sb_err, ecc_db_err}, 2'b00);
    chk("reset_count", ecc_sb_count, 16'h0);
    #4 HRESETN = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) do_write(4'(i), 4'hF, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full then partial write, read back after each.
    do_write(4'd5, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    do_read(4'd5);
    do_write(4'd5, 4'b0010, 32'h0000AA00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_read(4'd5);
    chk("partial_merge_model", m_data[5], 32'hDEADAAEF);

    // Single-bit injection, repeated reads, counter clear.
    do_write(4'd6, 4'hF, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0);
    do_read(4'd6);
    do_read(4'd6);
    do_clr();

    // Double-bit injection, then a partial write that must be suppressed.
    do_write(4'd7, 4'hF, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 1'b0);
    do_read(4'd7);
    do_write(4'd7, 4'b0001, 32'h00000055, 1'b0, 1'b0, 1'b0, 1'b0);
    do_read(4'd7);

    // Write and read together: write wins, read data holds.
    do_read(4'd5);
    do_write(4'd7, 4'hF, 32'hCAFE0007, 1'b0, 1'b0, 1'b1, 1'b0);
    do_read(4'd7);

    // Requests presented while busy are ignored.
    do_write(4'd4, 4'b1000, 32'hA1000000, 1'b0, 1'b0, 1'b0, 1'b1);
    do_read(4'd4);

    // Clear wins over an increment in the same cycle.
    mem_addr = 9'd6; mem_ren = 1'b1;
    tick();
    mem_ren = 1'b0;
    chk("clrp_sb_pulse", ecc_sb_err, m_flt[6] == 1);
    m_last = rd_word(4'd6); m_last_ok = 1'b1;
    ecc_clr_count = 1'b1;
    tick();
    ecc_clr_count = 1'b0; m_cnt = 0;
    chk("clrp_count", ecc_sb_count, m_cnt);

    // Reset during the RMW read aborts the write.
    mem_addr = 9'd5; mem_byteen = 4'b0100; mem_wdata = {8'h00, 32'h00770000}; mem_wen = 1'b1;
    tick();
    idle_in();
    chk("rst_rmw_busy", mem_busy, ECC);
    HRESETN = 1'b0;
    #1;
    chk("rst_busy", mem_busy, 1'b0);
    chk("rst_rdata", mem_rdata, 40'h0);
    chk("rst_count", ecc_sb_count, 16'h0);
    m_cnt = 0; m_last = '0; m_last_ok = 1'b1;
    if (!ECC) m_data[5] = merge(m_data[5], 4'b0100, 32'h00770000);
    #3 HRESETN = 1'b1;
    tick();
    do_read(4'd5);

    // Randomised traffic over a small address window.
    for (int k = 0; k < 400; k++) begin
      int r, n;
      logic [3:0] a, be;
      bit isb, idb;
      r = $urandom_range(0, 99);
      a = 4'($urandom_range(0, 15));
      n = $urandom_range(0, 9);
      isb = (n == 0);
      idb = (n == 1);
      if (r < 40) begin
        do_read(a);
      end else if (r < 65) begin
        be = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'hF;
        do_write(a, be, $urandom, isb, idb, $urandom_range(0, 4) == 0, 1'b0);
      end else if (r < 92) begin
        be = 4'($urandom_range(1, 14));
        do_write(a, be, $urandom, isb, idb, 1'b0, $urandom_range(0, 2) == 0);
      end else begin
        do_clr();
      end
    end

    for (int i = 0; i < 16; i++) do_read(4'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
